// File: rtl/playback_pkg.sv
// Shared types for the sample playback sequencer and its output buffer.
// Latency: none; declarations only.
// Backpressure: none; declarations only.
package playback_pkg;

   localparam int ADDR_W_DEF = 10;
   localparam int DATA_W_DEF = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   // One captured sample pair at the default widths. The top declares the
   // same {raw, filt, tag} layout at its own parameterised widths.
   typedef struct packed {
      logic [DATA_W_DEF-1:0] raw;
      logic [DATA_W_DEF-1:0] filt;
      logic [ADDR_W_DEF-1:0] tag;
   } entry_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO whose head entry is always register slot 0 (shift-on-pop).
// Latency: a write becomes visible at rd_dat/!empty on the following cycle.
// Backpressure: a write while full is refused unless a read happens in the same cycle.
//
// Ports: clk/rst (async active-low), wr_en/wr_dat (push side),
//        rd_en/rd_dat (pop side, rd_dat is the head), full/empty flags.
module sample_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_dat,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_dat,
   output logic             full,
   output logic             empty
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [WIDTH-1:0] mem     [DEPTH];
   logic [WIDTH-1:0] shifted [DEPTH];
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign pop    = rd_en & ~empty;
   assign push   = wr_en & (~full | pop);
   assign rd_dat = mem[0];

   // Contents as they would look after a pop; the top slot keeps its value.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) shifted[i] = mem[i];
      for (int i = 0; i < DEPTH - 1; i++) shifted[i] = mem[i+1];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (pop) begin
               // On a simultaneous pop the new entry lands one slot lower.
               if (push && (CNT_W'(i) == count - CNT_W'(1))) mem[i] <= wr_dat;
               else                                        mem[i] <= shifted[i];
            end else if (push && (CNT_W'(i) == count)) begin
               mem[i] <= wr_dat;
            end
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/sample_playback_ctrl.sv
// Sweeps the ROM address over [lo,hi] with a hold pace, captures settled (raw, filt) pairs, tags and buffers them.
// Latency: rom_addr=lo one cycle after start; first capture PIPE_LAT cycles after that; out_valid one cycle later.
// Backpressure: issuing never stalls; a capture arriving at a full FIFO is dropped and flags overflow.
//
// Ports: clk/rst (async active-low); start/stop/loop_en control; addr_lo/addr_hi/rate_div config;
//        rom_addr out, raw_in/filt_in in; out_valid/out_ready/out_raw/out_filt/out_tag stream;
//        busy, done, overflow, cfg_err status.
module sample_playback_ctrl
   import playback_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int PIPE_LAT   = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              loop_en,
   input  logic [ADDR_W-1:0] addr_lo,
   input  logic [ADDR_W-1:0] addr_hi,
   input  logic [7:0]        rate_div,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] raw_in,
   input  logic [DATA_W-1:0] filt_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_raw,
   output logic [DATA_W-1:0] out_filt,
   output logic [ADDR_W-1:0] out_tag,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              cfg_err
);
   localparam int DCNT_W = $clog2(PIPE_LAT) + 1;

   typedef struct packed {
      logic [DATA_W-1:0] raw;
      logic [DATA_W-1:0] filt;
      logic [ADDR_W-1:0] tag;
   } ent_t;

   state_t              state;
   logic [ADDR_W-1:0]   lo_q;
   logic [ADDR_W-1:0]   hi_q;
   logic [7:0]          div_q;
   logic [7:0]          div_cnt;
   logic [DCNT_W-1:0]   drain_cnt;
   logic                iss_vld;
   logic [PIPE_LAT-1:0] dl_vld;
   logic [ADDR_W-1:0]   dl_tag [PIPE_LAT];
   logic                cap_vld;
   logic                cap_drop;
   logic                pop;
   logic                fifo_full;
   logic                fifo_empty;
   ent_t                cap_ent;
   ent_t                head_ent;

   // iss_vld is registered alongside rom_addr, so the delay line sees the
   // issued address in the same cycle the ROM does.
   assign cap_vld  = dl_vld[PIPE_LAT-1];
   assign cap_ent  = '{raw: raw_in, filt: filt_in, tag: dl_tag[PIPE_LAT-1]};
   assign pop      = out_ready & ~fifo_empty;
   assign cap_drop = cap_vld & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dl_vld <= '0;
         for (int i = 0; i < PIPE_LAT; i++) dl_tag[i] <= '0;
      end else begin
         dl_vld[0] <= iss_vld;
         dl_tag[0] <= rom_addr;
         for (int i = 1; i < PIPE_LAT; i++) begin
            dl_vld[i] <= dl_vld[i-1];
            dl_tag[i] <= dl_tag[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         rom_addr  <= '0;
         lo_q      <= '0;
         hi_q      <= '0;
         div_q     <= '0;
         div_cnt   <= '0;
         drain_cnt <= '0;
         iss_vld   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         cfg_err   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         iss_vld <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (cap_drop) overflow <= 1'b1;

         case (state)
            IDLE: begin
               if (start) begin
                  if (addr_lo <= addr_hi) begin
                     state    <= RUN;
                     busy     <= 1'b1;
                     lo_q     <= addr_lo;
                     hi_q     <= addr_hi;
                     div_q    <= rate_div;
                     rom_addr <= addr_lo;
                     div_cnt  <= '0;
                     overflow <= 1'b0;
                     iss_vld  <= 1'b1;
                  end else begin
                     cfg_err  <= 1'b1;
                  end
               end
            end

            RUN: begin
               // stop beats an advance landing in the same cycle.
               if (stop) begin
                  state     <= DRAIN;
                  drain_cnt <= '0;
               end else if (div_cnt == div_q) begin
                  div_cnt <= '0;
                  if (rom_addr != hi_q) begin
                     rom_addr <= rom_addr + ADDR_W'(1);
                     iss_vld  <= 1'b1;
                  end else if (loop_en) begin
                     rom_addr <= lo_q;
                     iss_vld  <= 1'b1;
                  end else begin
                     state     <= DRAIN;
                     drain_cnt <= '0;
                  end
               end else begin
                  div_cnt <= div_cnt + 8'd1;
               end
            end

            DRAIN: begin
               // PIPE_LAT cycles is exactly long enough for the last issue
               // to reach the capture point.
               if (drain_cnt == DCNT_W'(PIPE_LAT - 1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  drain_cnt <= drain_cnt + DCNT_W'(1);
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   sample_fifo #(
      .WIDTH (2*DATA_W + ADDR_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (cap_vld),
      .wr_dat (cap_ent),
      .rd_en  (pop),
      .rd_dat (head_ent),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   assign out_valid = ~fifo_empty;
   assign out_raw   = head_ent.raw;
   assign out_filt  = head_ent.filt;
   assign out_tag   = head_ent.tag;

endmodule
